// File: rtl/x25519_pkg.sv
// Shared X25519 field constants and the reducer state type, used by the multiplier,
// the reducer and the ladder sequencer.
package x25519_pkg;

  localparam int unsigned FIELD_W = 255;
  localparam int unsigned WORD_W  = 256;
  localparam int unsigned PROD_W  = 512;

  localparam logic [WORD_W-1:0] P25519 = (256'd1 << 255) - 256'd19;

  // 2^256 = 38 and 2^255 = 19 (mod p)
  localparam int unsigned FOLD256 = 38;
  localparam int unsigned FOLD255 = 19;

  typedef enum logic [2:0] {
    StIdle,
    StF1,
    StF2,
    StF3,
    StCsub,
    StDone
  } red_state_e;

endpackage

// File: rtl/fp25519_reduce_if.sv
// Valid/ready handshake bundle between the multiplier, the reducer and the ladder sequencer.
interface fp25519_reduce_if;
  import x25519_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/fp25519_csub.sv
// Combinational compare-and-subtract: returns a - p when a >= p, else a.
// Correct only for a < 2p.
module fp25519_csub
  import x25519_pkg::*;
(
  input  logic [WORD_W-1:0] i_a,
  output logic [WORD_W-1:0] o_r
);

  logic [WORD_W:0] w_diff;

  // Top bit of the widened difference is the borrow, i.e. a < p.
  assign w_diff = {1'b0, i_a} - {1'b0, P25519};
  assign o_r    = w_diff[WORD_W] ? i_a : w_diff[WORD_W-1:0];

endmodule

// File: rtl/fp25519_reduce.sv
// Reduces a 512-bit product to the canonical residue mod 2^255-19 by three folding
// steps and one conditional subtraction; one operation in flight at a time.
module fp25519_reduce
  import x25519_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  fp25519_reduce_if.slave  bus
);

  red_state_e        r_state;
  logic [PROD_W-1:0] r_p;
  logic [262:0]      r_acc1;
  logic [256:0]      r_acc2;
  logic [WORD_W-1:0] r_acc3;
  logic [WORD_W-1:0] r_out_data;
  logic              r_out_valid;

  logic [262:0]      w_hi1;
  logic [262:0]      w_acc1;
  logic [256:0]      w_hi2;
  logic [256:0]      w_acc2;
  logic [WORD_W-1:0] w_hi3;
  logic [WORD_W-1:0] w_acc3;
  logic [WORD_W-1:0] w_csub;

  // Constant multiplies as shift-add: 38x = 32x + 4x + 2x, 19x = 16x + 2x + x.
  assign w_hi1  = {7'd0, r_p[PROD_W-1:WORD_W]};
  assign w_acc1 = {7'd0, r_p[WORD_W-1:0]} + (w_hi1 << 5) + (w_hi1 << 2) + (w_hi1 << 1);

  assign w_hi2  = {250'd0, r_acc1[262:256]};
  assign w_acc2 = {1'b0, r_acc1[WORD_W-1:0]} + (w_hi2 << 5) + (w_hi2 << 2) + (w_hi2 << 1);

  assign w_hi3  = {254'd0, r_acc2[256:FIELD_W]};
  assign w_acc3 = {1'b0, r_acc2[FIELD_W-1:0]} + (w_hi3 << 4) + (w_hi3 << 1) + w_hi3;

  fp25519_csub u_csub (
    .i_a (r_acc3),
    .o_r (w_csub)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_p         <= '0;
      r_acc1      <= '0;
      r_acc2      <= '0;
      r_acc3      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_p     <= bus.in_data;
            r_state <= StF1;
          end
        end
        StF1: begin
          r_acc1  <= w_acc1;
          r_state <= StF2;
        end
        StF2: begin
          r_acc2  <= w_acc2;
          r_state <= StF3;
        end
        StF3: begin
          r_acc3  <= w_acc3;
          r_state <= StCsub;
        end
        StCsub: begin
          r_out_data  <= w_csub;
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.busy      = (r_state != StIdle);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule
